// File: rtl/tt_rst_seq.sv
// Reset sequencer: synchronises release of the global reset, stretches it,
// then releases N_OUT active-low reset domains in a fixed staggered order.
module tt_rst_seq #(
   parameter int N_OUT       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH     = 16,
   parameter int STAGGER     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             soft_rst_req,
   output logic             soft_rst_ack,
   output logic [N_OUT-1:0] rst_n_out,
   output logic             ready
);

   localparam int MAXC = (STRETCH > STAGGER) ? STRETCH : STAGGER;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int IW   = $clog2(N_OUT + 1);

   localparam logic [CW-1:0] LD_STR = CW'(STRETCH - 1);
   localparam logic [CW-1:0] LD_STG = CW'(STAGGER - 1);
   localparam logic [IW-1:0] LAST   = IW'(N_OUT - 1);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_STRETCH,
      ST_STAGGER,
      ST_RUN
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [N_OUT-1:0] rst_n_q, rst_n_d;
   logic             ready_q, ready_d;
   logic             ack_q, ack_d;
   logic             pend_q, pend_d;
   logic             done;
   logic             soft_go;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_ok;

   assign sync_ok = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_n_q <= '0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_n_q <= rst_n_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_n_d = rst_n_q;
      ready_d = ready_q;
      ack_d   = ack_q;
      pend_d  = pend_q;
      done    = 1'b0;
      soft_go = (state_q == ST_RUN) && !ack_q && soft_rst_req;

      if (ack_q && !soft_rst_req) begin
         ack_d = 1'b0;
      end

      unique case (state_q)
         ST_HOLD: begin
            // Leave on the edge sync_ok rises so domain 0 lands STRETCH later.
            if (sync_q[SYNC_STAGES-2] || sync_ok) begin
               cnt_d   = LD_STR;
               state_d = ST_STRETCH;
            end
         end
         ST_STRETCH: begin
            if (cnt_q == '0) begin
               rst_n_d[0] = 1'b1;
               if (N_OUT == 1) begin
                  done = 1'b1;
               end else begin
                  cnt_d   = LD_STG;
                  idx_d   = IW'(1);
                  state_d = ST_STAGGER;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_STAGGER: begin
            if (cnt_q == '0) begin
               rst_n_d = rst_n_q | (N_OUT'(1) << idx_q);
               if (idx_q == LAST) begin
                  done = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
                  cnt_d = LD_STG;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_RUN: begin
            if (soft_go) begin
               rst_n_d = '0;
               ready_d = 1'b0;
               pend_d  = 1'b1;
               cnt_d   = LD_STR;
               state_d = ST_STRETCH;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase

      if (done) begin
         state_d = ST_RUN;
         ready_d = 1'b1;
         if (pend_q) begin
            ack_d  = 1'b1;
            pend_d = 1'b0;
         end
      end
   end

   assign rst_n_out    = rst_n_q;
   assign ready        = ready_q;
   assign soft_rst_ack = ack_q;

endmodule

// File: tb/tb_tt_rst_seq.sv
// Bench for tt_rst_seq: default build plus the N_OUT=1/STRETCH=1 corner,
// checked against an edge-count release model and hand-computed literals.
module tb_tt_rst_seq;

   logic       clk = 1'b0;
   logic [1:0] rst = 2'b11;
   logic [1:0] req = 2'b00;

   logic [3:0] rn0;
   logic       rdy0, ack0;
   logic       rn1;
   logic       rdy1, ack1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tt_rst_seq #(
      .N_OUT(4), .SYNC_STAGES(2), .STRETCH(16), .STAGGER(4)
   ) dut0 (
      .clk(clk), .rst(rst[0]), .soft_rst_req(req[0]),
      .soft_rst_ack(ack0), .rst_n_out(rn0), .ready(rdy0)
   );

   tt_rst_seq #(
      .N_OUT(1), .SYNC_STAGES(2), .STRETCH(1), .STAGGER(4)
   ) dut1 (
      .clk(clk), .rst(rst[1]), .soft_rst_req(req[1]),
      .soft_rst_ack(ack1), .rst_n_out(rn1), .ready(rdy1)
   );

   // Model: edges counted since release; domain k is free once the
   // count reaches base + STRETCH + k*STAGGER (base = sync depth or S).
   for (genvar g = 0; g < 2; g++) begin : m
      localparam int PN  = (g == 0) ? 4 : 1;
      localparam int PST = (g == 0) ? 16 : 1;
      localparam int PSG = 4;
      localparam int PSY = 2;

      int         e    = 0;
      int         base = PSY;
      bit         ack  = 1'b0;
      bit         pend = 1'b0;
      logic [3:0] exp_rn  = 4'h0;
      logic       exp_rd  = 1'b0;
      logic       exp_ack = 1'b0;

      function automatic bit rel(int t, int k);
         return t >= base + PST + k * PSG;
      endfunction

      function automatic logic [3:0] rstn(int t);
         logic [3:0] v;
         v = 4'h0;
         for (int k = 0; k < PN; k++) v[k] = rel(t, k);
         return v;
      endfunction

      function automatic bit rdy(int t);
         return rel(t, PN - 1);
      endfunction

      always @(posedge clk or posedge rst[g]) begin
         if (rst[g]) begin
            e    = 0;
            base = PSY;
            ack  = 1'b0;
            pend = 1'b0;
         end else begin
            bit r0, a0;
            r0 = rdy(e);
            a0 = ack;
            e  = e + 1;
            if (a0 && !req[g]) ack = 1'b0;
            if (r0 && !a0 && req[g]) begin
               base = e;
               pend = 1'b1;
            end else if (!r0 && rdy(e) && pend) begin
               ack  = 1'b1;
               pend = 1'b0;
            end
         end
         exp_rn  = rstn(e);
         exp_rd  = rdy(e);
         exp_ack = ack;
      end
   end

   task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            chk("mdl0", {2'b0, rn0, rdy0, ack0},
                {2'b0, m[0].exp_rn, m[0].exp_rd, m[0].exp_ack});
            chk("mdl1", {5'b0, rn1, rdy1, ack1},
                {5'b0, m[1].exp_rn[0], m[1].exp_rd, m[1].exp_ack});
         end
      join_none

      // power-on
      repeat (5) @(posedge clk);
      #1;
      chk("rst_rn0", rn0, 8'h0);
      chk("rst_rdy0", {rdy0, ack0}, 8'h0);
      @(negedge clk); #2 rst = 2'b00;
      tick(2);  chk("c1_e2_rn", rn1, 8'h0);
      tick(1);  chk("c1_e3_rn", rn1, 8'h1);
      chk("c1_e3_rdy", rdy1, 8'h1);
      tick(14); chk("e17_rn", rn0, 8'h0);
      tick(1);  chk("e18_rn", rn0, 8'h1);
      chk("e18_rdy", rdy0, 8'h0);
      tick(4);  chk("e22_rn", rn0, 8'h3);
      tick(4);  chk("e26_rn", rn0, 8'h7);
      tick(3);  chk("e29_rn", rn0, 8'h7);
      chk("e29_rdy", rdy0, 8'h0);
      tick(1);  chk("e30_rn", rn0, 8'hf);
      chk("e30_rdy", rdy0, 8'h1);

      // async assertion mid-stagger
      @(negedge clk); #2 rst[0] = 1'b1;
      tick(2);
      @(negedge clk); #2 rst[0] = 1'b0;
      tick(23); chk("a_e23_rn", rn0, 8'h3);
      #3 rst[0] = 1'b1;
      #1 chk("async_rn", rn0, 8'h0);
      chk("async_rdy", rdy0, 8'h0);
      tick(2);
      @(negedge clk); #2 rst[0] = 1'b0;
      tick(29); chk("a_e29_rn", rn0, 8'h7);
      tick(1);  chk("a_e30_rn", rn0, 8'hf);
      chk("a_e30_rdy", rdy0, 8'h1);

      // sub-cycle reset pulse
      @(posedge clk); #2 rst[0] = 1'b1;
      #2 rst[0] = 1'b0;
      #1 chk("pulse_rn", rn0, 8'h0);
      tick(29); chk("p_e29_rn", rn0, 8'h7);
      tick(1);  chk("p_e30_rn", rn0, 8'hf);

      // soft reset, held request, release, restart
      @(negedge clk); #2 req[0] = 1'b1;
      tick(1);  chk("s_S_rn", rn0, 8'h0);
      chk("s_S_rdy", {rdy0, ack0}, 8'h0);
      tick(15); chk("s_S15_rn", rn0, 8'h0);
      tick(1);  chk("s_S16_rn", rn0, 8'h1);
      tick(11); chk("s_S27_ra", {rdy0, ack0}, 8'h0);
      tick(1);  chk("s_S28_rn", rn0, 8'hf);
      chk("s_S28_ra", {rdy0, ack0}, 8'h3);
      tick(5);  chk("hold_rn", rn0, 8'hf);
      chk("hold_ack", ack0, 8'h1);
      @(negedge clk); #2 req[0] = 1'b0;
      tick(1);  chk("drop_ack", ack0, 8'h0);
      chk("drop_rn", rn0, 8'hf);
      @(negedge clk); #2 req[0] = 1'b1;
      tick(1);  chk("re_S_rn", rn0, 8'h0);
      tick(28); chk("re_S28_rn", rn0, 8'hf);
      chk("re_S28_ack", ack0, 8'h1);
      @(negedge clk); #2 req[0] = 1'b0;
      tick(1);  chk("re_drop", ack0, 8'h0);

      // request during stretch is dropped
      @(negedge clk); #2 rst[0] = 1'b1;
      @(negedge clk); #2 rst[0] = 1'b0;
      tick(9);
      @(negedge clk); #2 req[0] = 1'b1;
      tick(1);
      @(negedge clk); #2 req[0] = 1'b0;
      tick(20); chk("ign_e30_rn", rn0, 8'hf);
      chk("ign_e30_ra", {rdy0, ack0}, 8'h2);
      tick(3);  chk("ign_ack", ack0, 8'h0);

      // corner soft reset
      @(negedge clk); #2 req[1] = 1'b1;
      tick(1);  chk("c1_S_rn", {rn1, rdy1, ack1}, 8'h0);
      tick(1);  chk("c1_S1", {rn1, rdy1, ack1}, 8'h7);
      @(negedge clk); #2 req[1] = 1'b0;
      tick(1);  chk("c1_drop", {rn1, rdy1, ack1}, 8'h6);

      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
